ifmap_byte_fifo: RTL and testbench

Byte-granular ifmap FIFO sitting between the ifmap FIFO controller (write side, fed from GLB) and the PE array (read side). It accepts either a single byte or a 4-byte little-endian word per push, selected per cycle by a push-mode bit. It delivers one byte per pop with show-ahead data. It reports full, almost-full, empty and fill level back to the controller, and flags overflow and underflow as sticky errors.

---
 rtl/ifmap_fifo_pkg.sv | 23 ++
 rtl/ifmap_byte_fifo.sv | 131 +++++++++++++
 tb/tb_ifmap_byte_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_fifo_pkg
// Description : Constants shared by the ifmap FIFO controller and the
//               byte-granular ifmap FIFO (push-mode encoding, word size).
// Revision    : 1.0  initial release
// ============================================================================
package ifmap_fifo_pkg;

    // Push-mode encoding used on push_mod by both controller and FIFO
    localparam logic PUSH_BYTE = 1'b0;
    localparam logic PUSH_WORD = 1'b1;

    // Number of bytes carried by a word push
    localparam int WORD_BYTES = 4;

    // Bytes consumed by one push of the given mode
    function automatic logic [2:0] push_bytes(input logic mode);
        return (mode == PUSH_WORD) ? 3'd4 : 3'd1;
    endfunction

endpackage : ifmap_fifo_pkg
`default_nettype wire

// File: rtl/ifmap_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_byte_fifo
// Description : Byte-granular ifmap FIFO. Accepts a byte or a 4-byte
//               little-endian word per push, delivers one show-ahead byte
//               per pop, reports level flags and sticky over/underflow.
// Revision    : 1.0  initial release
// ============================================================================
module ifmap_byte_fifo
    import ifmap_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_reset_i,
    input  logic             push_i,
    input  logic             push_mod_i,
    input  logic [31:0]      push_data_i,
    input  logic             pop_i,
    output logic [7:0]       pop_data_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_WORD  = CNT_W'(WORD_BYTES);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [CNT_W-1:0] w_push_n;
    logic [CNT_W-1:0] w_free;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_add;
    logic [CNT_W-1:0] w_sub;
    logic [PTR_W-1:0] w_addr     [WORD_BYTES];
    logic [7:0]       w_lane_dat [WORD_BYTES];
    logic             w_lane_en  [WORD_BYTES];

    // Acceptance decisions use the registered count only; a same-cycle pop
    // never makes room for a push.
    always_comb begin
        w_push_n  = CNT_W'(push_bytes(push_mod_i));
        w_free    = C_DEPTH - r_count;
        w_push_ok = push_i && (w_free >= w_push_n);
        w_pop_ok  = pop_i && (r_count != '0);
        w_add     = w_push_ok ? w_push_n : '0;
        w_sub     = w_pop_ok ? CNT_W'(1) : '0;
    end

    // Four write lanes; lane k targets wp+k modulo DEPTH (pointer wrap is
    // natural in PTR_W bits). Lanes 1..3 are only used by word pushes.
    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
            assign w_addr[k]     = r_wp + PTR_W'(k);
            assign w_lane_dat[k] = push_data_i[8*k +: 8];
            assign w_lane_en[k]  = w_push_ok && ((k == 0) || (push_mod_i == PUSH_WORD));
        end
    endgenerate

    // Storage array: cleared only by the hard reset, untouched by fifo_reset_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!fifo_reset_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (w_lane_en[k]) begin
                    r_mem[w_addr[k]] <= w_lane_dat[k];
                end
            end
        end
    end

    // Pointers, fill count and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (fifo_reset_i) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + PTR_W'(w_push_n);
            end
            if (w_pop_ok) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            r_count <= r_count + w_add - w_sub;
            if (push_i && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop_i && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Status outputs decoded from registered state only
    always_comb begin
        pop_data_o    = r_mem[r_rp];
        count_o       = r_count;
        full_o        = (r_count == C_DEPTH);
        empty_o       = (r_count == '0);
        almost_full_o = ((C_DEPTH - r_count) < C_WORD);
        overflow_o    = r_overflow;
        underflow_o   = r_underflow;
    end

endmodule : ifmap_byte_fifo
`default_nettype wire

// File: tb/tb_ifmap_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifmap_byte_fifo
// Description : Scoreboard testbench for ifmap_byte_fifo (DEPTH = 16).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ifmap_byte_fifo;
    import ifmap_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             fifo_reset_i;
    logic             push_i;
    logic             push_mod_i;
    logic [31:0]      push_data_i;
    logic             pop_i;
    logic [7:0]       pop_data_o;
    logic             full_o;
    logic             almost_full_o;
    logic             empty_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic             underflow_o;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [7:0] sb_q [$];
    logic       m_ovf;
    logic       m_udf;

    ifmap_byte_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_reset_i (fifo_reset_i),
        .push_i       (push_i),
        .push_mod_i   (push_mod_i),
        .push_data_i  (push_data_i),
        .pop_i        (pop_i),
        .pop_data_o   (pop_data_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all status outputs against the model
    task automatic check_status(input string tag);
        int c;
        c = sb_q.size();
        check({tag, ".count"}, 32'(count_o), 32'(c));
        check({tag, ".empty"}, 32'(empty_o), 32'(c == 0));
        check({tag, ".full"}, 32'(full_o), 32'(c == DEPTH));
        check({tag, ".afull"}, 32'(almost_full_o), 32'((DEPTH - c) < 4));
        check({tag, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
        check({tag, ".udf"}, 32'(underflow_o), 32'(m_udf));
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge
    task automatic cycle(input logic push, input logic mode, input logic [31:0] data,
                         input logic pop, input string tag);
        int n;
        bit push_ok;
        bit pop_ok;
        n       = (mode == PUSH_WORD) ? 4 : 1;
        push_ok = push && ((DEPTH - sb_q.size()) >= n);
        pop_ok  = pop && (sb_q.size() != 0);
        push_i      = push;
        push_mod_i  = mode;
        push_data_i = data;
        pop_i       = pop;
        #1;
        if (pop_ok) begin
            check({tag, ".pop_data"}, 32'(pop_data_o), 32'(sb_q.pop_front()));
        end
        if (push && !push_ok) m_ovf = 1'b1;
        if (pop && !pop_ok)   m_udf = 1'b1;
        if (push_ok) begin
            for (int k = 0; k < n; k++) sb_q.push_back(data[8*k +: 8]);
        end
        @(posedge clk);
        #1;
        push_i = 1'b0;
        pop_i  = 1'b0;
        check_status(tag);
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic rst_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_status(tag);
        check({tag, ".pop_data"}, 32'(pop_data_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        fifo_reset_i = 1'b0;
        push_i       = 1'b0;
        push_mod_i   = PUSH_BYTE;
        push_data_i  = '0;
        pop_i        = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        check("reset.pop_data", 32'(pop_data_o), 32'h0);
        rst = 1'b0;

        // Byte stream
        cycle(1, PUSH_BYTE, 32'h11, 0, "b_push1");
        cycle(1, PUSH_BYTE, 32'h22, 0, "b_push2");
        cycle(1, PUSH_BYTE, 32'h33, 0, "b_push3");
        for (int i = 0; i < 3; i++) cycle(0, PUSH_BYTE, 0, 1, "b_pop");

        // Word order across the wrap: bring both pointers to 14
        rst_pulse("rst2");
        for (int i = 0; i < 14; i++) cycle(1, PUSH_BYTE, 32'(8'h40 + i), i > 0, "prefill");
        cycle(0, PUSH_BYTE, 0, 1, "predrain");
        cycle(1, PUSH_WORD, 32'hDDCCBBAA, 0, "wrap_word");
        for (int i = 0; i < 4; i++) cycle(0, PUSH_BYTE, 0, 1, "wrap_pop");

        // Almost-full, overflow on word, byte accepted, fill to full
        for (int i = 0; i < 13; i++) cycle(1, PUSH_BYTE, 32'(8'h80 + i), 0, "fill");
        cycle(1, PUSH_WORD, 32'h01020304, 0, "word_rej");
        cycle(1, PUSH_BYTE, 32'h9D, 0, "byte_acc");
        cycle(1, PUSH_BYTE, 32'h9E, 0, "fill15");
        cycle(1, PUSH_BYTE, 32'h9F, 0, "fill16");
        cycle(1, PUSH_BYTE, 32'hA0, 1, "full_pushpop");

        // Drain to 5, then word push + pop
        while (sb_q.size() > 5) cycle(0, PUSH_BYTE, 0, 1, "drain5");
        cycle(1, PUSH_WORD, 32'h55667788, 1, "word_pop");
        while (sb_q.size() > 0) cycle(0, PUSH_BYTE, 0, 1, "drain0");

        // Underflow, then synchronous clear with an ignored push
        cycle(0, PUSH_BYTE, 0, 1, "udf");
        fifo_reset_i = 1'b1;
        push_i       = 1'b1;
        push_mod_i   = PUSH_BYTE;
        push_data_i  = 32'hEE;
        @(posedge clk);
        #1;
        fifo_reset_i = 1'b0;
        push_i       = 1'b0;
        model_clear();
        check_status("sclr");

        // Push into empty with simultaneous pop
        cycle(1, PUSH_BYTE, 32'h5A, 1, "empty_pushpop");
        cycle(0, PUSH_BYTE, 0, 1, "empty_pushpop_drain");

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 2) != 0), "rand");
        end

        // Reset mid-burst
        cycle(1, PUSH_WORD, 32'hCAFEF00D, 0, "burst1");
        cycle(1, PUSH_WORD, 32'h12345678, 1, "burst2");
        push_i = 1'b1;
        rst_pulse("rst_mid");
        push_i = 1'b0;
        cycle(1, PUSH_BYTE, 32'h77, 0, "post_rst");
        cycle(0, PUSH_BYTE, 0, 1, "post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ifmap_byte_fifo
`default_nettype wire
